score_display_mux: RTL and testbench



---
 rtl/seg_pkg.sv | 22 ++
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/score_display_mux.sv | 103 ++++++++++
 tb/tb_score_display_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment codes, BCD nibble type, converter states and the pow10 helper
// shared by score_display_mux and bin2bcd_seq.
package seg_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

    localparam logic [9:0][7:0] SEG_DIGIT = {8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
                                             8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [7:0] seg_code(input bcd_t d);
        return d > 4'd9 ? SEG_BLANK : SEG_DIGIT[d];
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one magnitude bit per cycle,
// MSB first; done_o pulses for one cycle with the finished BCD on bcd_o.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VALUE_W    = 32,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [VALUE_W-1:0]    value_i,
    output logic                  ready_o,
    output logic                  done_o,
    output bcd_t [NUM_DIGITS-1:0] bcd_o
);
    localparam int CW = $clog2(VALUE_W + 1);

    conv_state_e           state_q, state_d;
    logic [VALUE_W-1:0]    bits_q, bits_d;
    bcd_t [NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) adj[i] = bcd_q[i] >= 4'd5 ? bcd_q[i] + 4'd3 : bcd_q[i];
        state_d = state_q;
        bits_d  = bits_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SHIFT;
                bits_d  = value_i;
                bcd_d   = '0;
                cnt_d   = '0;
            end
            SHIFT: begin
                {bcd_d, bits_d} = {adj, bits_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(VALUE_W - 1)) state_d = COMMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bits_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o = state_q == IDLE;
    assign done_o  = state_q == COMMIT;
    assign bcd_o   = bcd_q;
endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: signed score to multiplexed common-anode seven-segment display.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros and float '-' next to the top digit.
module score_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic signed [VALUE_W-1:0] i_score,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      o_overflow
);
    localparam logic [63:0] LIM_POS = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [63:0] LIM_NEG = pow10(NUM_DIGITS - 1) - 64'd1;
    localparam int CNT_W  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int SLOT_W = $clog2(NUM_DIGITS);

    logic                  neg_in, ovf_in, ready, done;
    logic [VALUE_W-1:0]    mag_in;
    bcd_t [NUM_DIGITS-1:0] bcd, digit_q;
    logic                  neg_p_q, ovf_p_q, neg_q, ovf_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SLOT_W-1:0]     slot_q, slot_d, d_idx;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic [SLOT_W-1:0]     msd;
`endif

    assign neg_in = i_score[VALUE_W-1];
    assign mag_in = neg_in ? -i_score : i_score;
    assign ovf_in = 64'(mag_in) > (neg_in ? LIM_NEG : LIM_POS);

    bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .start_i(1'b1),
        .value_i(mag_in),
        .ready_o(ready),
        .done_o (done),
        .bcd_o  (bcd)
    );

    // sign and overflow are latched with the magnitude and committed with the digits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            neg_p_q <= 1'b0;
            ovf_p_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            digit_q <= '0;
        end else begin
            if (ready) begin
                neg_p_q <= neg_in;
                ovf_p_q <= ovf_in;
            end
            if (done) begin
                neg_q   <= neg_p_q;
                ovf_q   <= ovf_p_q;
                digit_q <= bcd;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q == CNT_W'(REFRESH_DIV - 1) ? '0 : cnt_q + 1'b1;
        slot_d = cnt_q != CNT_W'(REFRESH_DIV - 1) ? slot_q :
                 slot_q == SLOT_W'(NUM_DIGITS - 1) ? '0 : slot_q + 1'b1;
        d_idx  = SLOT_W'(NUM_DIGITS - 1) - slot_q;
        an_d   = ~(NUM_DIGITS'(1) << d_idx);
`ifdef LEADING_ZERO_BLANK_EN
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) if (digit_q[SLOT_W'(i)] != 4'd0) msd = SLOT_W'(i);
        seg_d = ovf_q ? SEG_DASH :
                d_idx <= msd ? seg_code(digit_q[d_idx]) :
                (neg_q && 32'(d_idx) == 32'(msd) + 1) ? SEG_DASH : SEG_BLANK;
`else
        seg_d = (ovf_q || (neg_q && slot_q == '0)) ? SEG_DASH : seg_code(digit_q[d_idx]);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            slot_q <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: scoreboard bench for score_display_mux with NUM_DIGITS=4,
// VALUE_W=32, REFRESH_DIV=4; expected scan frames are queued and checked per slot change.
module tb_score_display_mux;
    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       ovf;
        string      tag;
    } frame_t;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic signed [31:0] i_score = 32'sd0;
    logic [7:0]         seg;
    logic [3:0]         an;
    logic               o_overflow;

    frame_t     q[$];
    frame_t     mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         dwell = 0;
    bit         dwell_ok = 1'b0;
    logic [3:0] prev_an = 4'hF;
    int         bad;
    int         base;

    localparam int NV = 11;
    logic signed [31:0] vscore [NV] = '{32'sd1234, 32'sd7, -32'sd42, -32'sd999, 32'sd9999,
                                        -32'sd1000, 32'sd10000, 32'sh80000000, 32'sd0,
                                        -32'sd9, 32'sd100};
    logic               vovf [NV]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                        1'b0, 1'b0, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0]  Z0 = 8'hFF;
    localparam logic [31:0] ZF = 32'hFFFFFFC0;
    logic [31:0] vseg [NV] = '{32'hF9A4B099, 32'hFFFFFFF8, 32'hFFBF99A4, 32'hBF909090,
                               32'h90909090, 32'hBFBFBFBF, 32'hBFBFBFBF, 32'hBFBFBFBF,
                               32'hFFFFFFC0, 32'hFFFFBF90, 32'hFFF9C0C0};
`else
    localparam logic [7:0]  Z0 = 8'hC0;
    localparam logic [31:0] ZF = 32'hC0C0C0C0;
    logic [31:0] vseg [NV] = '{32'hF9A4B099, 32'hC0C0C0F8, 32'hBFC099A4, 32'hBF909090,
                               32'h90909090, 32'hBFBFBFBF, 32'hBFBFBFBF, 32'hBFBFBFBF,
                               32'hC0C0C0C0, 32'hBFC0C090, 32'hC0F9C0C0};
`endif

    score_display_mux #(.NUM_DIGITS(4), .VALUE_W(32), .REFRESH_DIV(4)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_score   (i_score),
        .seg       (seg),
        .an        (an),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= i_rst ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] slot_seg(input logic [31:0] segs, input logic [3:0] a);
        return a == 4'b0111 ? segs[31:24] : a == 4'b1011 ? segs[23:16] :
               a == 4'b1101 ? segs[15:8]  : a == 4'b1110 ? segs[7:0]   : 8'h00;
    endfunction

    // monitor: every new slot presented on an pops one expected frame
    always @(negedge clk) begin
        if (i_rst || an == 4'hF) begin
            dwell = 0;
            dwell_ok = 1'b0;
            prev_an = an;
        end else if (an == prev_an) begin
            dwell++;
        end else begin
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk({mon_e.tag, " an"}, 32'(an), 32'(mon_e.an));
                chk({mon_e.tag, " seg"}, 32'(seg), 32'(mon_e.seg));
                chk({mon_e.tag, " ovf"}, 32'(o_overflow), 32'(mon_e.ovf));
                if (dwell_ok) chk({mon_e.tag, " dwell"}, dwell, 4);
            end
            dwell = 1;
            dwell_ok = 1'b1;
            prev_an = an;
        end
    end

    task automatic expect_frames(input string name, input logic [31:0] segs, input logic ovf);
        frame_t f;
        int n;
        n = 0;
        while (an !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk({name, " sync"}, 32'(an), 32'b1110);
            return;
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            f.an  = ~(4'b1000 >> k);
            f.seg = segs[31-8*k -: 8];
            f.ovf = ovf;
            f.tag = name;
            q.push_back(f);
        end
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " drain"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_score = 32'sd1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset seg", 32'(seg), 32'hFF);
        chk("reset an", 32'(an), 32'hF);
        chk("reset ovf", 32'(o_overflow), 0);
        @(posedge clk);
        #1 i_rst = 1'b0;

        for (int k = 0; k < 100 && cyc != 34; k++) @(negedge clk);
        chk("pre-commit an", 32'(an), 32'b0111);
        chk("pre-commit seg", 32'(seg), 32'(Z0));
        @(negedge clk);
        chk("commit latency seg", 32'(seg), 32'hF9);
        expect_frames("first 1234", 32'hF9A4B099, 1'b0);

        for (int v = 0; v < NV; v++) begin
            @(posedge clk);
            #1 i_score = vscore[v];
            repeat (72) @(posedge clk);
            expect_frames($sformatf("vec%0d", v), vseg[v], vovf[v]);
        end

        @(posedge clk);
        #1 i_score = 32'sd1234;
        repeat (72) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 40 && cyc % 34 != 5; k++) @(negedge clk);
        base = cyc;
        i_score = 32'sd5678;
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            if (seg !== slot_seg(32'hF9A4B099, an)) bad++;
            @(negedge clk);
        end
        chk("hold 1234 during shift", bad, 0);
        chk("hold window length", cyc - base, 64);
        expect_frames("then 5678", 32'h9282F880, 1'b0);

        @(posedge clk);
        #1 i_score = 32'sd10000;
        repeat (72) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 40 && cyc % 34 != 10; k++) @(negedge clk);
        chk("pre-reset ovf", 32'(o_overflow), 1);
        @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset seg", 32'(seg), 32'hFF);
        chk("mid reset an", 32'(an), 32'hF);
        chk("mid reset ovf", 32'(o_overflow), 0);
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("mid reset an 2", 32'(an), 32'hF);
        @(negedge clk);
        chk("post reset an", 32'(an), 32'b0111);
        chk("post reset seg", 32'(seg), 32'(Z0));
        expect_frames("post reset zero", ZF, 1'b0);
        repeat (72) @(posedge clk);
        expect_frames("post reset 10000", 32'hBFBFBFBF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
